// File: rtl/dma_seq_pkg.sv
// dma_seq_pkg: shared state, address-source and rmw codes for the dma address sequencer
package dma_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_FIX    = 3'd2,
    S_READ   = 3'd3,
    S_MODIFY = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6
  } state_e;
  localparam logic [2:0] ADCTL_NONE    = 3'd0;
  localparam logic [2:0] ADCTL_BASE    = 3'd1;
  localparam logic [2:0] ADCTL_BASE_X  = 3'd2;
  localparam logic [2:0] ADCTL_BASE_Y  = 3'd3;
  localparam logic [2:0] ADCTL_PAGEFIX = 3'd4;
  localparam logic RMW_INC = 1'b0;
  localparam logic RMW_DEC = 1'b1;
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_X    = 2'd1;
  localparam logic [1:0] SEL_Y    = 2'd2;
endpackage

// File: rtl/dma_addr_seq_if.sv
// dma_addr_seq_if: request handshake, memory port and status bundle of the dma address sequencer
interface dma_addr_seq_if #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 8,
  parameter int DATA_W = 8
) ();
  logic              start_valid;
  logic              start_ready;
  logic [ADDR_W-1:0] base_addr;
  logic [IDX_W-1:0]  x_idx;
  logic [IDX_W-1:0]  y_idx;
  logic              xskip;
  logic              yskip;
  logic              page;
  logic              rmwB;
  logic              rmw_op;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [2:0]        adctl;
  logic [2:0]        state;
  logic              done;
  logic              page_cross;
  logic [DATA_W-1:0] rdata_out;
  modport slave (
    input  start_valid, base_addr, x_idx, y_idx, xskip, yskip, page, rmwB, rmw_op, mem_ack, mem_rdata,
    output start_ready, mem_req, mem_we, mem_addr, mem_wdata, adctl, state, done, page_cross, rdata_out
  );
  modport master (
    output start_valid, base_addr, x_idx, y_idx, xskip, yskip, page, rmwB, rmw_op, mem_ack, mem_rdata,
    input  start_ready, mem_req, mem_we, mem_addr, mem_wdata, adctl, state, done, page_cross, rdata_out
  );
endinterface

// File: rtl/dma_addr_calc.sv
// dma_addr_calc: effective address (base plus optional zero-extended index) and page-cross flag
module dma_addr_calc
  import dma_seq_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int IDX_W     = 8,
  parameter int PAGE_BITS = 8
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [IDX_W-1:0]  index,
  input  logic [1:0]        select,
  output logic [ADDR_W-1:0] eff,
  output logic              page_cross
);
  assign eff = base + (select == SEL_NONE ? '0 : ADDR_W'(index));
  assign page_cross = eff[ADDR_W-1:PAGE_BITS] != base[ADDR_W-1:PAGE_BITS];
endmodule

// File: rtl/dma_addr_seq.sv
// dma_addr_seq: per-request dma operand sequencer (index add, page fix-up, read, optional rmw write)
module dma_addr_seq
  import dma_seq_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int IDX_W     = 8,
  parameter int DATA_W    = 8,
  parameter int PAGE_BITS = 8
) (
  input logic           clk,
  input logic           rst,
  dma_addr_seq_if.slave bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, eff_q, eff_d, calc_eff;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        sel_q, sel_d;
  logic              page_q, page_d, rmw_q, rmw_d, op_q, op_d, pc_q, pc_d, calc_pc;
  logic [DATA_W-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  dma_addr_calc #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .PAGE_BITS(PAGE_BITS)) u_calc (
    .base(base_q), .index(idx_q), .select(sel_q), .eff(calc_eff), .page_cross(calc_pc)
  );
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    page_d  = page_q;
    rmw_d   = rmw_q;
    op_d    = op_q;
    eff_d   = eff_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: if (bus.start_valid) begin
        state_d = S_ADDR;
        base_d  = bus.base_addr;
        idx_d   = bus.xskip ? bus.x_idx : bus.y_idx;
        sel_d   = bus.xskip ? SEL_X : bus.yskip ? SEL_Y : SEL_NONE;
        page_d  = bus.page;
        rmw_d   = bus.rmwB;
        op_d    = bus.rmw_op;
      end
      S_ADDR: begin
        eff_d   = calc_eff;
        pc_d    = calc_pc;
        state_d = calc_pc && page_q ? S_FIX : S_READ;
      end
      S_FIX: state_d = S_READ;
      S_READ: if (bus.mem_ack) begin
        rdata_d = bus.mem_rdata;
        state_d = rmw_q ? S_MODIFY : S_DONE;
      end
      S_MODIFY: begin
        wdata_d = op_q == RMW_DEC ? rdata_q - DATA_W'(1) : rdata_q + DATA_W'(1);
        state_d = S_WRITE;
      end
      S_WRITE: state_d = bus.mem_ack ? S_DONE : S_WRITE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      sel_q   <= SEL_NONE;
      page_q  <= 1'b0;
      rmw_q   <= 1'b0;
      op_q    <= RMW_INC;
      eff_q   <= '0;
      pc_q    <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      page_q  <= page_d;
      rmw_q   <= rmw_d;
      op_q    <= op_d;
      eff_q   <= eff_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.start_ready = state_q == S_IDLE && !rst;
  assign bus.mem_req     = state_q == S_READ || state_q == S_WRITE;
  assign bus.mem_we      = state_q == S_WRITE;
  assign bus.mem_addr    = eff_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.adctl       = state_q == S_FIX ? ADCTL_PAGEFIX :
                           state_q != S_ADDR ? ADCTL_NONE :
                           sel_q == SEL_X ? ADCTL_BASE_X :
                           sel_q == SEL_Y ? ADCTL_BASE_Y : ADCTL_BASE;
  assign bus.state       = state_q;
  assign bus.done        = state_q == S_DONE;
  assign bus.page_cross  = pc_q;
  assign bus.rdata_out   = rdata_q;
endmodule

// File: tb/tb_dma_addr_seq.sv
// tb_dma_addr_seq: directed and randomized transactions checked against a cycle-count reference model
module tb_dma_addr_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dma_addr_seq_if bus ();
  dma_addr_seq dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic scramble();
    bus.base_addr = 16'($urandom);
    bus.x_idx     = 8'($urandom);
    bus.y_idx     = 8'($urandom);
    bus.xskip     = 1'($urandom);
    bus.yskip     = 1'($urandom);
    bus.page      = 1'($urandom);
    bus.rmwB      = 1'($urandom);
    bus.rmw_op    = 1'($urandom);
    bus.mem_rdata = 8'($urandom);
  endtask
  task automatic run_txn(input logic [15:0] base, input logic [7:0] x, input logic [7:0] y,
                         input logic xs, input logic ys, input logic pg, input logic rmw,
                         input logic op, input logic [7:0] rd, input int wr, input int ww,
                         input logic abort);
    int idx, sel, eff, n_done, stall, wexp;
    logic pc, fix, got_done, seen_req, stopped, wrote, prev_hold;
    logic [24:0] prev_bus;
    idx = xs ? int'(x) : ys ? int'(y) : 0;
    sel = xs ? 1 : ys ? 2 : 0;
    eff = (int'(base) + idx) % 65536;
    pc = (eff / 256) != (int'(base) / 256);
    fix = pc && pg;
    wexp = op ? (int'(rd) + 255) % 256 : (int'(rd) + 1) % 256;
    n_done = 3 + int'(fix) + wr + (rmw ? 2 + ww : 0);
    stall = 0;
    got_done = 0;
    seen_req = 0;
    stopped = 0;
    wrote = 0;
    prev_hold = 0;
    prev_bus = '0;
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.base_addr = base;
    bus.x_idx = x;
    bus.y_idx = y;
    bus.xskip = xs;
    bus.yskip = ys;
    bus.page = pg;
    bus.rmwB = rmw;
    bus.rmw_op = op;
    check("ready", bus.start_ready, 1);
    for (int n = 1; n <= 60 && !got_done && !stopped; n++) begin
      @(negedge clk);
      bus.start_valid = 1'($urandom);
      scramble();
      if (n == 1) begin
        check("adctl_addr", bus.adctl, 32'(sel + 1));
        check("state_addr", bus.state, 1);
      end
      if (fix && n == 2) begin
        check("adctl_fix", bus.adctl, 4);
        check("req_fix", bus.mem_req, 0);
      end
      if (bus.mem_req) begin
        if (!seen_req) begin
          check("read_start", n, 32'(2 + int'(fix)));
          check("read_we", bus.mem_we, 0);
          seen_req = 1;
        end
        check("addr", bus.mem_addr, eff);
        if (prev_hold) check("stable", {bus.mem_addr, bus.mem_we, bus.mem_wdata}, 32'(prev_bus));
        prev_bus = {bus.mem_addr, bus.mem_we, bus.mem_wdata};
        if (abort && bus.mem_we && stall == 1) begin
          rst = 1'b1;
          bus.mem_ack = 1'b0;
          bus.start_valid = 1'b0;
          @(negedge clk);
          check("abort_req", bus.mem_req, 0);
          check("abort_state", bus.state, 0);
          check("abort_done", bus.done, 0);
          check("abort_ready", bus.start_ready, 0);
          rst = 1'b0;
          stopped = 1;
        end else begin
          bus.mem_ack = stall == (bus.mem_we ? ww : wr);
          bus.mem_rdata = bus.mem_we ? 8'($urandom) : rd;
          if (bus.mem_ack && bus.mem_we) begin
            check("wdata", bus.mem_wdata, 32'(wexp));
            wrote = 1;
          end
          stall = bus.mem_ack ? 0 : stall + 1;
          prev_hold = !bus.mem_ack;
        end
      end else begin
        prev_hold = 0;
        bus.mem_ack = 1'($urandom);
        if (bus.done) begin
          check("done_cycle", n, 32'(n_done));
          check("rdata_out", bus.rdata_out, rd);
          check("page_cross", bus.page_cross, pc);
          check("wrote", wrote, rmw);
          got_done = 1;
          bus.start_valid = 1'b0;
          bus.mem_ack = 1'b0;
        end
      end
    end
    bus.start_valid = 1'b0;
    bus.mem_ack = 1'b0;
    if (!abort) check("timeout", got_done, 1);
    @(negedge clk);
    check("done_once", bus.done, 0);
    check("ready_after", bus.start_ready, 1);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    bus.start_valid = 1'b0;
    bus.mem_ack = 1'b0;
    scramble();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ctl", {bus.mem_req, bus.mem_we, bus.adctl, bus.state, bus.done, bus.page_cross, bus.start_ready}, 0);
      check("rst_data", {bus.mem_addr, bus.mem_wdata, bus.rdata_out}, 0);
      bus.start_valid = 1'($urandom);
      bus.mem_ack = 1'($urandom);
      scramble();
    end
    bus.start_valid = 1'b0;
    bus.mem_ack = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("ready_release", bus.start_ready, 1);
    run_txn(16'h1234, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 0, 0, 0);
    run_txn(16'h12F0, 8'h20, 8'h00, 1, 0, 1, 0, 0, 8'h11, 0, 0, 0);
    run_txn(16'h12F0, 8'h20, 8'h00, 1, 0, 0, 0, 0, 8'h22, 0, 0, 0);
    run_txn(16'h0040, 8'h00, 8'h00, 0, 0, 0, 1, 0, 8'hFF, 3, 3, 0);
    run_txn(16'hFFF0, 8'h00, 8'h20, 0, 1, 0, 0, 0, 8'h33, 0, 0, 0);
    run_txn(16'h0100, 8'h05, 8'h07, 1, 1, 1, 1, 1, 8'h80, 1, 5, 1);
    run_txn(16'h0200, 8'h10, 8'h00, 1, 0, 1, 1, 1, 8'h00, 0, 0, 0);
    for (int t = 0; t < 200; t++) begin
      run_txn(16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
